serdes_link: RTL and testbench
==============================

// Module: serdes_link
// PURPOSE
//  Parametrised serial link: a framed serializer (TX) and a mid-bit-sampling deserializer (RX).
//  Successor to the fixed 8-bit connect_ser_des pair. Adds width/rate generics, valid/ready
//  handshakes, error detection and a selectable internal loopback. Sits between a parallel
//  producer/consumer and a single-wire serial line.
// PARAMETERS
//  W    8  data word width, 1..32
//  DIV  4  clocks per serial bit, >=2, even; elaboration error otherwise
// PORTS
//  clk         in   1  single clock, rising edge
//  nreset      in   1  asynchronous active-low reset
//  in_data     in   W  TX word
//  in_valid    in   1  TX word offered
//  in_ready    out  1  TX can accept (TX FSM idle)
//  out_data    out  W  received word
//  out_valid   out  1  received word held
//  out_ready   in   1  consumer takes word
//  ser_tx      out  1  serial line out, idle high
//  ser_rx      in   1  serial line in (async to frame, synchronised internally)
//  lb_en       in   1  1: RX input = ser_tx (internal loopback), ser_rx ignored
//  err_frame   out  1  1-cycle pulse: stop bit sampled 0
//  err_parity  out  1  1-cycle pulse: parity mismatch (0 when parity compiled out)
//  err_overrun out  1  1-cycle pulse: word completed while out_valid && !out_ready
// BEHAVIOUR
//  Reset: ser_tx=1, in_ready=1, out_valid=0, out_data=0, all err_*=0, both FSMs IDLE, counters 0.
//  Reset mid-frame aborts immediately. No partial word is delivered after reset.
//  Frame: start(0), W data bits LSB first, [parity], stop(1). F = W+2(+1) bits, each DIV clocks.
//  TX FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   - Accept on in_valid&&in_ready (cycle 0). Latch word. in_ready=0 from cycle 1.
//   - ser_tx drives start bit from cycle 1. All outputs registered.
//   - in_ready returns 1 in the cycle after the last stop-bit cycle. Back-to-back frames have no gap.
//  RX input path: mux (lb_en) -> 2-flop synchroniser -> FSM IDLE->START->DATA->[PARITY]->STOP->IDLE.
//   - IDLE: line==0 starts a bit counter. At DIV/2 the line is rechecked.
//   - Recheck 1 = false start, return to IDLE, no pulse. Otherwise sample every DIV clocks.
//   - Stop sampled at its mid-bit, then immediately IDLE, so a directly following start is caught.
//   - Stop==0: err_frame pulse, word discarded. Parity bad: err_parity pulse, word discarded.
//     Both bad: both pulse, same cycle.
//  Output buffer (1 entry): on a good word, if !out_valid || out_ready, load out_data and set out_valid.
//   - Otherwise err_overrun pulses. New word dropped, held word unchanged.
//   - out_valid clears on out_ready unless reloaded the same cycle.
//   - out_data is stable while out_valid && !out_ready.
//  Loopback latency: out_valid rises <= F*DIV+4 cycles after acceptance.
//  lb_en change is legal only while both FSMs are IDLE. Otherwise the result is undefined but
//  must be recovered by the next valid start.
// CONFIGURATION
//  SERDES_PARITY_EN defined: even-parity bit inserted after data (XOR of data plus parity = 0).
//   - RX checks it. F = W+3.
//  Not defined: no PARITY state. F = W+2. err_parity tied 0.
// STRUCTURE
//  serdes_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP) and localparam helpers
//   (frame length, counter widths via $clog2).
//  One sub-module: serdes_rx_deser, holding the synchroniser, RX FSM and shift register, and
//   emitting word + good/frame/parity strobes.
//  TX FSM and the output buffer live in serdes_link.
// TESTING (W=8, DIV=4, lb_en=1 unless noted)
//  1 Send 0xA5, out_ready=1 -> out_data=0xA5, out_valid 1 cycle, ser_tx bit order 0,1,0,1,0,0,1,0,1[,p=0],1.
//  2 Stream 0x00,0xFF,0x3C back-to-back, in_valid held -> no idle gap on ser_tx, all 3 words
//    received in order, no errors.
//  3 out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, err_overrun pulses once.
//    Then out_ready=1 -> out_valid clears.
//  4 lb_en=0, bench drives ser_rx frame with stop=0 -> err_frame pulse, out_valid stays 0.
//    A 1-clock low glitch -> no response.
//  5 SERDES_PARITY_EN, bench frame 0x01 with parity=0 -> err_parity pulse, word dropped.
//    Correct parity=1 -> 0x01 received.
//  6 Assert nreset mid-DATA of 0x5A -> ser_tx=1, in_ready=1 at once.
//    After release, send 0x77 -> only 0x77 received.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared FSM state type and sizing helpers for the serdes_link serial link.
// Defining SERDES_PARITY_EN adds an even-parity bit to every frame.
package serdes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

`ifdef SERDES_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned w);
    return w + 2 + ParityBits;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serdes_rx_deser.sv
// Serial receiver: 2-flop synchroniser, mid-bit sampling FSM and shift register.
// Emits a word with registered good/frame/parity strobes; parity check under SERDES_PARITY_EN.
module serdes_rx_deser
  import serdes_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned DIV = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         line_i,
  output logic [W-1:0] word_o,
  output logic         good_o,
  output logic         frame_err_o,
  output logic         parity_err_o
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam int unsigned IdxW = cnt_width(frame_len(W));
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(DIV / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(W - 1);

  logic            sync1_q, sync2_q;
  logic            line;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    sh_q, sh_next, word_q;
  logic            par_bad;
  logic            good_q, frame_err_q, parity_err_q;

  // Synchroniser resets to the idle (high) line level so reset cannot fake a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;

  // LSB arrives first, so new bits enter at the top and walk down.
  if (W == 1) begin : gen_sh_one
    assign sh_next = line;
  end else begin : gen_sh_multi
    assign sh_next = {line, sh_q[W-1:1]};
  end

`ifdef SERDES_PARITY_EN
  logic par_q;
  assign par_bad = par_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_q         <= '0;
      word_q       <= '0;
      good_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef SERDES_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      good_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!line) begin
            cnt_q   <= '0;
            state_q <= StStart;
          end
        end
        StStart: begin
          // Recheck at mid start bit; a high line here was only a glitch.
          if (cnt_q == CntHalf) begin
            cnt_q   <= '0;
            idx_q   <= '0;
`ifdef SERDES_PARITY_EN
            par_q   <= 1'b0;
`endif
            state_q <= line ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            sh_q  <= sh_next;
`ifdef SERDES_PARITY_EN
            par_q <= par_q ^ line;
`endif
            if (idx_q == IdxLast) begin
`ifdef SERDES_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
`ifdef SERDES_PARITY_EN
            par_q   <= par_q ^ line;
`endif
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          // Back to idle straight from mid stop bit so a following start is not missed.
          if (cnt_q == CntLast) begin
            cnt_q        <= '0;
            state_q      <= StIdle;
            frame_err_q  <= ~line;
            parity_err_q <= par_bad;
            if (line && !par_bad) begin
              good_q <= 1'b1;
              word_q <= sh_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign word_o       = word_q;
  assign good_o       = good_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: rtl/serdes_link.sv
// Framed serial link: TX serializer FSM, RX deserializer, 1-entry output buffer, loopback mux.
// SERDES_PARITY_EN enables an even-parity bit after the data bits.
module serdes_link
  import serdes_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ser_tx,
  input  logic         ser_rx,
  input  logic         lb_en,
  output logic         err_frame,
  output logic         err_parity,
  output logic         err_overrun
);

  if (W < 1 || W > 32) begin : gen_bad_w
    $error("serdes_link: W must be in 1..32");
  end
  if (DIV < 2 || (DIV % 2) != 0) begin : gen_bad_div
    $error("serdes_link: DIV must be even and >= 2");
  end

  localparam int unsigned CntW = cnt_width(DIV);
  localparam int unsigned IdxW = cnt_width(frame_len(W));
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(W - 1);

  state_e          tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [IdxW-1:0] tx_idx_q;
  logic [W-1:0]    tx_sh_q, tx_sh_next;
  logic            ser_tx_q, in_ready_q;

`ifdef SERDES_PARITY_EN
  logic tx_par_q;
`endif

  assign tx_sh_next = tx_sh_q >> 1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      ser_tx_q   <= 1'b1;
      in_ready_q <= 1'b1;
`ifdef SERDES_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          if (in_valid) begin
            tx_sh_q    <= in_data;
`ifdef SERDES_PARITY_EN
            tx_par_q   <= ^in_data;
`endif
            tx_cnt_q   <= '0;
            ser_tx_q   <= 1'b0;
            in_ready_q <= 1'b0;
            tx_state_q <= StStart;
          end
        end
        StStart: begin
          if (tx_cnt_q == CntLast) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            ser_tx_q   <= tx_sh_q[0];
            tx_state_q <= StData;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (tx_cnt_q == CntLast) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == IdxLast) begin
`ifdef SERDES_PARITY_EN
              ser_tx_q   <= tx_par_q;
              tx_state_q <= StParity;
`else
              ser_tx_q   <= 1'b1;
              tx_state_q <= StStop;
`endif
            end else begin
              tx_idx_q <= tx_idx_q + 1'b1;
              tx_sh_q  <= tx_sh_next;
              ser_tx_q <= tx_sh_next[0];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        StParity: begin
          if (tx_cnt_q == CntLast) begin
            tx_cnt_q   <= '0;
            ser_tx_q   <= 1'b1;
            tx_state_q <= StStop;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tx_cnt_q == CntLast) begin
            tx_cnt_q   <= '0;
            in_ready_q <= 1'b1;
            tx_state_q <= StIdle;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          ser_tx_q   <= 1'b1;
          in_ready_q <= 1'b1;
          tx_state_q <= StIdle;
        end
      endcase
    end
  end

  assign ser_tx   = ser_tx_q;
  assign in_ready = in_ready_q;

  logic         rx_line;
  logic [W-1:0] rx_word;
  logic         rx_good, rx_frame_err, rx_parity_err;

  assign rx_line = lb_en ? ser_tx_q : ser_rx;

  serdes_rx_deser #(
    .W   (W),
    .DIV (DIV)
  ) u_rx (
    .clk_i        (clk),
    .rst_ni       (nreset),
    .line_i       (rx_line),
    .word_o       (rx_word),
    .good_o       (rx_good),
    .frame_err_o  (rx_frame_err),
    .parity_err_o (rx_parity_err)
  );

  logic [W-1:0] out_data_q;
  logic         out_valid_q, err_overrun_q;

  // A held, untaken word has priority: the newcomer is dropped and flagged.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_overrun_q <= 1'b0;
      if (rx_good) begin
        if (!out_valid_q || out_ready) begin
          out_data_q  <= rx_word;
          out_valid_q <= 1'b1;
        end else begin
          err_overrun_q <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_overrun = err_overrun_q;
  assign err_frame   = rx_frame_err;
  assign err_parity  = rx_parity_err;

endmodule

// File: tb/tb_serdes_link.sv
// Scoreboard bench for serdes_link (W=8, DIV=4): stimulus pushes expected words, a negedge
// monitor pops them on each out_valid&&out_ready transfer and tallies error pulses.
module tb_serdes_link;

  localparam int W   = 8;
  localparam int DIV = 4;
`ifdef SERDES_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic         clk = 1'b0;
  logic         nreset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         ser_tx;
  logic         ser_rx;
  logic         lb_en;
  logic         err_frame, err_parity, err_overrun;

  serdes_link #(
    .W   (W),
    .DIV (DIV)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ser_tx      (ser_tx),
    .ser_rx      (ser_rx),
    .lb_en       (lb_en),
    .err_frame   (err_frame),
    .err_parity  (err_parity),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int n_rise = 0, n_vcyc = 0, n_frame = 0, n_parity = 0, n_over = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] want;
    if (nreset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", out_data);
        end else begin
          want = exp_q.pop_front();
          check("rx_word", 32'(out_data), 32'(want));
        end
      end
      if (out_valid) n_vcyc++;
      if (out_valid && !prev_valid) begin
        n_rise++;
        rise_cyc = cyc;
      end
      if (err_frame) n_frame++;
      if (err_parity) n_parity++;
      if (err_overrun) n_over++;
    end
    prev_valid = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_word(input logic [7:0] w, input bit hold, output int acc);
    bit got = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 for word 0x%0h", w);
      in_valid = 1'b0;
      acc = cyc;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4 * F * DIV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d word(s) outstanding, expected 0", name, exp_q.size());
    end
    repeat (4) tick();
  endtask

  task automatic drive_rx(input logic [10:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      ser_rx = bits[k];
      repeat (DIV) tick();
    end
    ser_rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] exp_frame, cap, fb;
    int acc0, lat;
    int acc[3];
    int b_rise, b_vcyc, b_frame, b_par, b_over;
    logic [7:0] words[3];

    nreset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; ser_rx = 1'b1; lb_en = 1'b1;
    repeat (3) tick();
    check("reset_ser_tx", 32'(ser_tx), 1);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_data", 32'(out_data), 0);
    check("reset_errs", 32'({err_frame, err_parity, err_overrun}), 0);
    @(negedge clk) nreset = 1'b1;
    tick();

    // 1: 0xA5 in loopback, frame bits sampled mid-bit on ser_tx
`ifdef SERDES_PARITY_EN
    exp_frame = 11'h54A;
`else
    exp_frame = 11'h34A;
`endif
    b_rise = n_rise; b_vcyc = n_vcyc;
    exp_q.push_back(8'hA5);
    accept_word(8'hA5, 1'b0, acc0);
    cap = '0;
    repeat (DIV / 2) @(posedge clk);
    @(negedge clk) cap[0] = ser_tx;
    for (int k = 1; k < F; k++) begin
      repeat (DIV) @(posedge clk);
      @(negedge clk) cap[k] = ser_tx;
    end
    check("t1_tx_frame_bits", 32'(cap), 32'(exp_frame));
    drain("t1_drain");
    check("t1_valid_rises", 32'(n_rise - b_rise), 1);
    check("t1_valid_cycles", 32'(n_vcyc - b_vcyc), 1);
    lat = rise_cyc - acc0 + 1;
    checks++;
    if (lat < 1 || lat > F * DIV + 4) begin
      failures++;
      $display("FAIL t1_latency: got %0d cycles, required 1..%0d", lat, F * DIV + 4);
    end

    // 2: back-to-back stream with in_valid held
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    b_rise = n_rise; b_frame = n_frame; b_par = n_parity; b_over = n_over;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      accept_word(words[i], i < 2, acc[i]);
    end
    drain("t2_drain");
    check("t2_gap_0_1", 32'(acc[1] - acc[0]), 32'(F * DIV + 1));
    check("t2_gap_1_2", 32'(acc[2] - acc[1]), 32'(F * DIV + 1));
    check("t2_valid_rises", 32'(n_rise - b_rise), 3);
    check("t2_errors", 32'((n_frame - b_frame) + (n_parity - b_par) + (n_over - b_over)), 0);

    // 3: consumer stalled, second word overruns
    out_ready = 1'b0;
    b_over = n_over;
    exp_q.push_back(8'h11);
    accept_word(8'h11, 1'b0, acc0);
    accept_word(8'h22, 1'b0, acc0);
    repeat (F * DIV + 12) tick();
    check("t3_held_valid", 32'(out_valid), 1);
    check("t3_held_data", 32'(out_data), 32'h11);
    check("t3_overrun_pulses", 32'(n_over - b_over), 1);
    out_ready = 1'b1;
    tick();
    check("t3_valid_cleared", 32'(out_valid), 0);
    check("t3_queue_empty", 32'(exp_q.size()), 0);

    // 4: external line, bad stop bit then a 1-clock glitch
    lb_en = 1'b0;
    tick();
    b_rise = n_rise; b_frame = n_frame; b_par = n_parity;
`ifdef SERDES_PARITY_EN
    fb = {1'b0, 1'b0, 8'h3C, 1'b0};
`else
    fb = {1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
`endif
    drive_rx(fb, F);
    repeat (3 * DIV) tick();
    check("t4_frame_pulses", 32'(n_frame - b_frame), 1);
    check("t4_no_parity_err", 32'(n_parity - b_par), 0);
    check("t4_no_word", 32'(n_rise - b_rise), 0);
    b_frame = n_frame;
    ser_rx = 1'b0;
    tick();
    ser_rx = 1'b1;
    repeat (4 * DIV) tick();
    check("t4_glitch_no_err", 32'((n_frame - b_frame) + (n_parity - b_par)), 0);
    check("t4_glitch_no_word", 32'(n_rise - b_rise), 0);

    // 5: external frames for 0x01
    b_rise = n_rise; b_frame = n_frame; b_par = n_parity;
`ifdef SERDES_PARITY_EN
    fb = {1'b0, 1'b1, 1'b0, 8'h01, 1'b0};
    drive_rx(fb, F);
    repeat (3 * DIV) tick();
    check("t5_parity_pulse", 32'(n_parity - b_par), 1);
    check("t5_bad_dropped", 32'(n_rise - b_rise), 0);
    fb = {1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
`else
    fb = {1'b0, 1'b0, 1'b1, 8'h01, 1'b0};
`endif
    exp_q.push_back(8'h01);
    drive_rx(fb, F);
    drain("t5_drain");
    check("t5_good_word", 32'(n_rise - b_rise), 1);
    check("t5_no_frame_err", 32'(n_frame - b_frame), 0);

    // 6: reset in the middle of 0x5A, then 0x77 only
    lb_en = 1'b1;
    tick();
    accept_word(8'h5A, 1'b0, acc0);
    repeat (3 * DIV) tick();
    nreset = 1'b0;
    #1;
    check("t6_reset_ser_tx", 32'(ser_tx), 1);
    check("t6_reset_in_ready", 32'(in_ready), 1);
    check("t6_reset_out_valid", 32'(out_valid), 0);
    repeat (3) tick();
    @(negedge clk) nreset = 1'b1;
    tick();
    b_rise = n_rise; b_frame = n_frame; b_par = n_parity; b_over = n_over;
    exp_q.push_back(8'h77);
    accept_word(8'h77, 1'b0, acc0);
    drain("t6_drain");
    repeat (F * DIV) tick();
    check("t6_one_word", 32'(n_rise - b_rise), 1);
    check("t6_errors", 32'((n_frame - b_frame) + (n_parity - b_par) + (n_over - b_over)), 0);

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
